// File: rtl/checkbits_pkg.sv
// Shared register map, status bit positions and word type for the check-bit pacer.
package checkbits_pkg;

  typedef logic [15:0] word_t;

  localparam logic [3:0] DATA_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] HOLD_OFS   = 4'h8;
  localparam logic [3:0] CTRL_OFS   = 4'hC;

  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_BUSY_BIT  = 10;

  typedef enum logic [1:0] {
    REG_DATA   = DATA_OFS[3:2],
    REG_STATUS = STATUS_OFS[3:2],
    REG_HOLD   = HOLD_OFS[3:2],
    REG_CTRL   = CTRL_OFS[3:2]
  } reg_sel_t;

endpackage

// File: rtl/checkbits_fifo.sv
// Synchronous word FIFO with occupancy count; push is refused when full, pop when empty.
module checkbits_fifo
  import checkbits_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  word_t         wdata,
  output word_t         rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  word_t         mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    logic [AW-1:0] nxt;
    if (ptr == LAST_PTR) begin
      nxt = {AW{1'b0}};
    end else begin
      nxt = ptr + AW'(1'b1);
    end
    return nxt;
  endfunction

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push & (count_r != FULL_CNT);
    pop_ok_s  = pop & (count_r != {CW{1'b0}});
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so stale words never reach the pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/checkbits_pacer.sv
// Wishbone slave that paces firmware status words onto mprj_io[31:16], holding each
// word for at least HOLD+1 cycles so consecutive writes stay distinguishable.
module checkbits_pacer
  import checkbits_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          HOLD_RST = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        axis_clk,
  input  logic        axis_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb
);

  localparam int    CW        = $clog2(DEPTH + 1);
  localparam word_t HOLD_INIT = 16'(HOLD_RST);

  logic          ack_r;
  logic [31:0]   dat_o_r;
  word_t         io_out_r;
  logic [15:0]   io_oeb_r;
  word_t         hold_reg_r;
  word_t         hold_cnt_r;
  logic          oe_en_r;

  reg_sel_t      sel_s;
  logic          req_s;
  logic          data_push_req_s;
  logic          stall_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          wr_hold_s;
  logic          wr_ctrl_s;
  logic          busy_s;
  logic [31:0]   rd_data_s;
  word_t         head_s;
  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;
  logic          unused_s;

  checkbits_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wbs_dat_i[15:0]),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Decode: a request is only seen when ack is low, so each ack is a one-cycle pulse.
  // A push into a full FIFO is stalled until an earlier edge has freed a slot.
  always_comb begin
    sel_s           = reg_sel_t'(wbs_adr_i[3:2]);
    req_s           = wbs_cyc_i & wbs_stb_i & ~ack_r
                    & (wbs_adr_i[31:4] == BASE_ADR[31:4])
                    & (wbs_adr_i[3:0] <= CTRL_OFS);
    data_push_req_s = wbs_we_i & (sel_s == REG_DATA) & (|wbs_sel_i[1:0]);
    stall_s         = data_push_req_s & full_s;
    accept_s        = req_s & ~stall_s;
    push_s          = accept_s & data_push_req_s;
    wr_hold_s       = accept_s & wbs_we_i & (sel_s == REG_HOLD);
    wr_ctrl_s       = accept_s & wbs_we_i & (sel_s == REG_CTRL);
    busy_s          = (hold_cnt_r != 16'h0000);
    pop_s           = ~empty_s & ~busy_s;
  end

  // Read-data mux for the four registers.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (sel_s)
      REG_DATA:   rd_data_s = {16'h0000, io_out_r};
      REG_STATUS: begin
        rd_data_s[7:0]            = 8'(count_s);
        rd_data_s[STAT_EMPTY_BIT] = empty_s;
        rd_data_s[STAT_FULL_BIT]  = full_s;
        rd_data_s[STAT_BUSY_BIT]  = busy_s;
      end
      REG_HOLD:   rd_data_s = {16'h0000, hold_reg_r};
      REG_CTRL:   rd_data_s = {31'h0000_0000, oe_en_r};
      default:    rd_data_s = 32'h0000_0000;
    endcase
  end

  // Wishbone acknowledge and registered read data.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ack_r   <= 1'b0;
      dat_o_r <= 32'h0000_0000;
    end else begin
      ack_r <= accept_s;
      if (accept_s && !wbs_we_i) begin
        dat_o_r <= rd_data_s;
      end else begin
        dat_o_r <= 32'h0000_0000;
      end
    end
  end

  // HOLD and CTRL registers; the pad enable is registered straight from CTRL.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      hold_reg_r <= HOLD_INIT;
      oe_en_r    <= 1'b0;
      io_oeb_r   <= 16'hFFFF;
    end else begin
      if (wr_hold_s) begin
        hold_reg_r <= wbs_dat_i[15:0];
      end
      if (wr_ctrl_s) begin
        oe_en_r  <= wbs_dat_i[0];
        io_oeb_r <= wbs_dat_i[0] ? 16'h0000 : 16'hFFFF;
      end
    end
  end

  // Drain: HOLD is sampled only at a pop, so a mid-hold change affects the next word.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      io_out_r   <= 16'h0000;
      hold_cnt_r <= 16'h0000;
    end else if (pop_s) begin
      io_out_r   <= head_s;
      hold_cnt_r <= hold_reg_r;
    end else if (busy_s) begin
      hold_cnt_r <= hold_cnt_r - 16'h0001;
    end
  end

  assign unused_s  = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};
  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_o_r;
  assign io_out    = io_out_r;
  assign io_oeb    = io_oeb_r;

endmodule

// File: tb/tb_checkbits_pacer.sv
// Directed bench for checkbits_pacer: register access, hold pacing, back-pressure and reset.
module tb_checkbits_pacer;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_DATA = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_HOLD = 32'h3000_0008;
  localparam logic [31:0] A_CTRL = 32'h3000_000C;

  logic        axis_clk   = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        wbs_cyc_i  = 1'b0;
  logic        wbs_stb_i  = 1'b0;
  logic        wbs_we_i   = 1'b0;
  logic [3:0]  wbs_sel_i  = 4'h0;
  logic [31:0] wbs_adr_i  = 32'h0;
  logic [31:0] wbs_dat_i  = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] io_out;
  logic [15:0] io_oeb;

  int total = 0;
  int bad   = 0;

  checkbits_pacer dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .io_out     (io_out),
    .io_oeb     (io_oeb)
  );

  always #5 axis_clk = ~axis_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check(tag, {16'h0000, obs}, {16'h0000, exp});
  endtask

  // Called at #1 after a rising edge; returns #1 after the edge that raised ack (or the bound).
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int max_cyc,
                          output int cyc, output bit acked, output logic [31:0] rdat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    cyc   = 0;
    acked = 1'b0;
    rdat  = 32'h0;
    while (!acked && cyc < max_cyc) begin
      @(posedge axis_clk);
      #1;
      cyc++;
      if (wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    output int cyc);
    bit          a;
    logic [31:0] d;
    wb_cycle(1'b1, adr, dat, 4'hF, 200, cyc, a, d);
    check({tag, "_ack"}, {31'h0, a}, 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    bit          a;
    int          c;
    logic [31:0] d;
    wb_cycle(1'b0, adr, 32'h0, 4'hF, 50, c, a, d);
    check({tag, "_ack"}, {31'h0, a}, 32'd1);
    check(tag, d, exp);
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  initial begin
    int          c;
    int          n;
    bit          a;
    logic [31:0] d;
    logic [15:0] dv [6];
    logic [15:0] prev;
    logic [15:0] xv [3];

    // Reset state.
    repeat (3) @(posedge axis_clk);
    #2;
    check16("rst_io_out", io_out, 16'h0000);
    check16("rst_io_oeb", io_oeb, 16'hFFFF);
    check("rst_ack", {31'h0, wbs_ack_o}, 32'd0);
    check("rst_dat_o", wbs_dat_o, 32'h0);
    step();
    axis_rst_n = 1'b1;
    rd_check("rst_status", A_STAT, 32'h0000_0100);
    rd_check("rst_ctrl", A_CTRL, 32'h0);
    rd_check("rst_hold", A_HOLD, 32'h0000_0010);

    // Undecoded offset and foreign base get no ack.
    wb_cycle(1'b1, BASE + 32'hE, 32'h1, 4'hF, 8, c, a, d);
    check("noack_ofs_e", {31'h0, a}, 32'd0);
    wb_cycle(1'b0, 32'h3000_0010, 32'h0, 4'hF, 8, c, a, d);
    check("noack_base", {31'h0, a}, 32'd0);

    // Two back-to-back status words, HOLD = 3.
    wr("ctrl_w", A_CTRL, 32'h1, c);
    wr("hold_w3", A_HOLD, 32'd3, c);
    rd_check("ctrl_rb", A_CTRL, 32'h1);
    check16("oeb_en", io_oeb, 16'h0000);
    step();
    wr("ab40_w", A_DATA, 32'h0000_AB40, c);
    check16("ab40_not_yet", io_out, 16'h0000);
    step();
    check16("ab40_next_edge", io_out, 16'hAB40);
    wr("ab51_w", A_DATA, 32'h0000_AB51, c);
    check("ab51_w_cyc", 32'(c), 32'd1);
    n = 0;
    while (io_out === 16'hAB40 && n < 20) begin
      step();
      n++;
    end
    check("ab40_hold_len", 32'(n), 32'd3);
    check16("ab51_shown", io_out, 16'hAB51);
    repeat (10) step();
    check16("ab51_steady", io_out, 16'hAB51);
    rd_check("idle_status", A_STAT, 32'h0000_0100);

    // Back-pressure with HOLD = 100 and six words into a 4-deep FIFO.
    for (int i = 0; i < 6; i++) dv[i] = 16'hD000 + 16'(i);
    wr("hold_w100", A_HOLD, 32'd100, c);
    for (int i = 0; i < 5; i++) begin
      wr("bp_w", A_DATA, {16'h0000, dv[i]}, c);
      check("bp_w_cyc", 32'(c), 32'd2);
      if (i == 1) check16("bp_d0_out", io_out, dv[0]);
    end
    wr("bp_w6", A_DATA, {16'h0000, dv[5]}, c);
    check("bp_w6_stall", 32'(c), 32'd95);
    check16("bp_d1_out", io_out, dv[1]);
    for (int k = 2; k < 6; k++) begin
      prev = dv[k-1];
      n = 0;
      while (io_out === prev && n < 300) begin
        step();
        n++;
      end
      check16("bp_order", io_out, dv[k]);
      check("bp_spacing", 32'(n), (k == 2) ? 32'd100 : 32'd101);
    end
    rd_check("bp_busy_status", A_STAT, 32'h0000_0500);

    // HOLD = 0 bursts: queued words leave on consecutive cycles; repeated for pointer wrap.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) xv[i] = 16'h7000 + 16'(b * 16 + i);
      wr("burst_hold20", A_HOLD, 32'd20, c);
      wr("burst_dummy", A_DATA, 32'h0000_5A00 + 32'(b), c);
      for (int i = 0; i < 3; i++) wr("burst_w", A_DATA, {16'h0000, xv[i]}, c);
      wr("burst_hold0", A_HOLD, 32'd0, c);
      n = 0;
      while (io_out !== xv[0] && n < 300) begin
        step();
        n++;
      end
      check16("burst_x0", io_out, xv[0]);
      step();
      check16("burst_x1", io_out, xv[1]);
      step();
      check16("burst_x2", io_out, xv[2]);
      step();
      check16("burst_x2_held", io_out, xv[2]);
    end

    // Upper-lane-only DATA write: acked, nothing pushed.
    rd_check("sel_pre_status", A_STAT, 32'h0000_0100);
    wb_cycle(1'b1, A_DATA, 32'h0000_EEEE, 4'b1100, 20, c, a, d);
    check("sel_hi_ack", {31'h0, a}, 32'd1);
    rd_check("sel_post_status", A_STAT, 32'h0000_0100);
    repeat (3) step();
    check16("sel_io_out", io_out, 16'h7022);

    // Reset mid-hold with two entries queued.
    wr("rst_hold50", A_HOLD, 32'd50, c);
    wr("rst_y0", A_DATA, 32'h0000_9100, c);
    wr("rst_y1", A_DATA, 32'h0000_9101, c);
    wr("rst_y2", A_DATA, 32'h0000_9102, c);
    rd_check("pre_rst_status", A_STAT, 32'h0000_0402);
    check16("pre_rst_io_out", io_out, 16'h9100);
    @(posedge axis_clk);
    #3;
    axis_rst_n = 1'b0;
    #1;
    check16("async_rst_io_out", io_out, 16'h0000);
    check16("async_rst_io_oeb", io_oeb, 16'hFFFF);
    check("async_rst_ack", {31'h0, wbs_ack_o}, 32'd0);
    repeat (2) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    rd_check("post_rst_status", A_STAT, 32'h0000_0100);
    rd_check("post_rst_ctrl", A_CTRL, 32'h0);
    rd_check("post_rst_hold", A_HOLD, 32'h0000_0010);
    check16("post_rst_io_out", io_out, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
